// File: rtl/count_pkg.sv
// Shared types for the count scheduler: counter mode codes, FSM states and the latched job record.
package count_pkg;

  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;
  localparam int WRAP_W = 5;

  typedef enum logic [1:0] {
    PLUSONE    = 2'b00,
    MINUSONE   = 2'b01,
    MINUSTHREE = 2'b10,
    LOAD       = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef struct packed {
    mode_t             modo;
    logic [DATA_W-1:0] d;
    logic [LEN_W-1:0]  len;
    logic              id;
  } job_t;

endpackage

// File: rtl/count_scheduler_if.sv
// Bundles the two requester ports, the external counter port and the completion report.
interface count_scheduler_if;
  import count_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [1:0]        req0_modo;
  logic [DATA_W-1:0] req0_d;
  logic [LEN_W-1:0]  req0_len;

  logic              req1_valid;
  logic              req1_ready;
  logic [1:0]        req1_modo;
  logic [DATA_W-1:0] req1_d;
  logic [LEN_W-1:0]  req1_len;

  logic              cnt_enable;
  logic [1:0]        cnt_modo;
  logic [DATA_W-1:0] cnt_d;
  logic              cnt_reset;
  logic [DATA_W-1:0] cnt_q;
  logic              cnt_rco;

  logic              done;
  logic              done_id;
  logic [DATA_W-1:0] done_q;
  logic [WRAP_W-1:0] done_wraps;
  logic              busy;

  modport master (
    output req0_valid, req0_modo, req0_d, req0_len,
    input  req0_ready,
    output req1_valid, req1_modo, req1_d, req1_len,
    input  req1_ready,
    input  cnt_enable, cnt_modo, cnt_d, cnt_reset,
    output cnt_q, cnt_rco,
    input  done, done_id, done_q, done_wraps, busy
  );

  modport slave (
    input  req0_valid, req0_modo, req0_d, req0_len,
    output req0_ready,
    input  req1_valid, req1_modo, req1_d, req1_len,
    output req1_ready,
    output cnt_enable, cnt_modo, cnt_d, cnt_reset,
    input  cnt_q, cnt_rco,
    output done, done_id, done_q, done_wraps, busy
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the requester not served last.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;  // 0 favours req0, 1 favours req1

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    else                grant = valid;
  end

  always_ff @(posedge clk) begin
    if (!reset)       ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/count_scheduler.sv
// Arbitrates two requesters and sequences each accepted job onto an external 4-bit counter.
module count_scheduler
  import count_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  count_scheduler_if.slave bus
);

  state_t            state;
  job_t              job;
  job_t              req_job;
  logic [LEN_W-1:0]  run_cnt;
  logic              en_r;
  logic              en_d1;
  logic [WRAP_W-1:0] wraps;
  logic [WRAP_W-1:0] wraps_next;
  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              idle;
  logic              accept;

  assign valid = {bus.req1_valid, bus.req0_valid};
  assign idle  = (state == ST_IDLE);

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .advance (accept),
    .grant   (grant)
  );

  assign bus.req0_ready = reset & idle & grant[0];
  assign bus.req1_ready = reset & idle & grant[1];
  assign accept = (bus.req0_ready & bus.req0_valid) | (bus.req1_ready & bus.req1_valid);

  always_comb begin
    req_job = '0;
    req_job.id = grant[1];
    if (grant[1]) begin
      req_job.modo = mode_t'(bus.req1_modo);
      req_job.d    = bus.req1_d;
      req_job.len  = bus.req1_len;
    end else begin
      req_job.modo = mode_t'(bus.req0_modo);
      req_job.d    = bus.req0_d;
      req_job.len  = bus.req0_len;
    end
  end

  // Reset overrides the counter controls combinationally so the counter clears on the same edge.
  assign bus.cnt_enable = ~reset | en_r;
  assign bus.cnt_reset  = ~reset;
  assign bus.cnt_modo   = reset ? job.modo : PLUSONE;
  assign bus.cnt_d      = job.d;
  assign bus.busy       = ~idle;

  // rco is only meaningful one cycle after a step actually happened.
  assign wraps_next = wraps + WRAP_W'(en_d1 & bus.cnt_rco);

  always_ff @(posedge clk) begin
    if (accept) job <= req_job;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      en_r           <= 1'b0;
      en_d1          <= 1'b0;
      run_cnt        <= '0;
      wraps          <= '0;
      bus.done       <= 1'b0;
      bus.done_id    <= 1'b0;
      bus.done_q     <= '0;
      bus.done_wraps <= '0;
    end else begin
      en_d1    <= en_r;
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_RUN;
            en_r    <= 1'b1;
            run_cnt <= '0;
            wraps   <= '0;
          end
        end
        ST_RUN: begin
          wraps <= wraps_next;
          if (run_cnt == job.len) begin
            en_r  <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            run_cnt <= run_cnt + LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          wraps          <= wraps_next;
          bus.done_q     <= bus.cnt_q;
          bus.done_wraps <= wraps_next;
          bus.done_id    <= job.id;
          bus.done       <= 1'b1;
          state          <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Scoreboard bench for count_scheduler with a behavioural 4-bit mode counter attached.
module tb_count_scheduler;
  import count_pkg::*;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  typedef struct {
    logic       id;
    logic [3:0] q;
    logic [4:0] w;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  count_scheduler_if bus();

  count_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter: rco flags a wrap on the step just taken, and is set by a load.
  always @(posedge clk) begin
    if (bus.cnt_enable) begin
      if (bus.cnt_reset) begin
        bus.cnt_q   <= 4'd0;
        bus.cnt_rco <= 1'b0;
      end else begin
        case (bus.cnt_modo)
          2'b00: begin bus.cnt_q <= bus.cnt_q + 4'd1; bus.cnt_rco <= (bus.cnt_q == 4'd15); end
          2'b01: begin bus.cnt_q <= bus.cnt_q - 4'd1; bus.cnt_rco <= (bus.cnt_q == 4'd0); end
          2'b10: begin bus.cnt_q <= bus.cnt_q - 4'd3; bus.cnt_rco <= (bus.cnt_q < 4'd3); end
          default: begin bus.cnt_q <= bus.cnt_d; bus.cnt_rco <= 1'b1; end
        endcase
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_id", 32'(bus.done_id), 32'(mon_e.id));
        chk("done_q", 32'(bus.done_q), 32'(mon_e.q));
        chk("done_wraps", 32'(bus.done_wraps), 32'(mon_e.w));
        chk("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic drive_req(input bit id, input logic v, input logic [1:0] modo,
                           input logic [3:0] d, input logic [3:0] len);
    if (id) begin
      bus.req1_valid = v; bus.req1_modo = modo; bus.req1_d = d; bus.req1_len = len;
    end else begin
      bus.req0_valid = v; bus.req0_modo = modo; bus.req0_d = d; bus.req0_len = len;
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic run_job(input bit id, input logic [1:0] modo, input logic [3:0] d,
                         input logic [3:0] len, input logic [3:0] exp_q,
                         input logic [4:0] exp_w, input bit poke);
    exp_t e;
    bit got;
    @(negedge clk);
    drive_req(id, 1'b1, modo, d, len);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      fail_now("accept");
      drive_req(id, 1'b0, modo, d, len);
      return;
    end
    e.id = id; e.q = exp_q; e.w = exp_w; e.due = cyc + int'(len) + 3;
    sb.push_back(e);
    @(posedge clk);
    #1 drive_req(id, 1'b0, modo, d, len);
    if (poke) begin
      @(negedge clk);
      drive_req(!id, 1'b1, LOAD, 4'd7, 4'd0);
      #1 chk("ready_in_run", 32'(id ? bus.req0_ready : bus.req1_ready), 0);
      @(negedge clk);
      drive_req(!id, 1'b0, LOAD, 4'd7, 4'd0);
    end
    wait_idle("job_idle");
    #1;
    chk("hold_done_q", 32'(bus.done_q), 32'(exp_q));
    chk("hold_done_wraps", 32'(bus.done_wraps), 32'(exp_w));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit got;
    reset = 1'b0;
    drive_req(1'b0, 1'b1, LOAD, 4'd0, 4'd0);
    drive_req(1'b1, 1'b0, PLUSONE, 4'd0, 4'd0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    chk("rst_cnt_enable", 32'(bus.cnt_enable), 1);
    chk("rst_cnt_reset", 32'(bus.cnt_reset), 1);
    chk("rst_cnt_modo", 32'(bus.cnt_modo), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_done_q", 32'(bus.done_q), 0);
    chk("rst_done_wraps", 32'(bus.done_wraps), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cnt_q", 32'(bus.cnt_q), 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_job(1'b0, LOAD, 4'd9, 4'd0, 4'd9, 5'd1, 1'b0);
    run_job(1'b0, LOAD, 4'd14, 4'd0, 4'd14, 5'd1, 1'b0);
    run_job(1'b1, PLUSONE, 4'd0, 4'd3, 4'd2, 5'd1, 1'b1);
    run_job(1'b1, LOAD, 4'd1, 4'd0, 4'd1, 5'd1, 1'b0);
    run_job(1'b0, MINUSTHREE, 4'd0, 4'd1, 4'd11, 5'd1, 1'b0);
    run_job(1'b1, MINUSONE, 4'd0, 4'd2, 4'd8, 5'd0, 1'b0);
    run_job(1'b0, LOAD, 4'd0, 4'd0, 4'd0, 5'd1, 1'b0);
    run_job(1'b1, PLUSONE, 4'd5, 4'd15, 4'd0, 5'd1, 1'b0);

    // Both requesters held valid from reset: service must alternate
    @(negedge clk);
    reset = 1'b0;
    drive_req(1'b0, 1'b1, PLUSONE, 4'd0, 4'd0);
    drive_req(1'b1, 1'b1, MINUSONE, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_both_ready0", 32'(bus.req0_ready), 0);
    chk("rst_both_ready1", 32'(bus.req1_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        #1;
        if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin got = 1'b1; break; end
        @(negedge clk);
      end
      if (!got) begin fail_now("arb_accept"); break; end
      chk("arb_winner", 32'(bus.req1_ready), k % 2);
      chk("arb_loser_ready", 32'(k % 2 == 1 ? bus.req0_ready : bus.req1_ready), 0);
      e.id = (k % 2 == 1); e.q = (k % 2 == 0) ? 4'd1 : 4'd0; e.w = 5'd0; e.due = cyc + 3;
      sb.push_back(e);
      @(posedge clk);
      if (k == 3) begin
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    wait_idle("arb_idle");

    // Reset during the third RUN cycle aborts the job
    @(negedge clk);
    drive_req(1'b0, 1'b1, PLUSONE, 4'd0, 4'd7);
    #1;
    if (bus.req0_ready !== 1'b1) fail_now("abort_accept");
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_cnt_q", 32'(bus.cnt_q), 0);
    chk("abort_ready0", 32'(bus.req0_ready), 0);
    chk("abort_ready1", 32'(bus.req1_ready), 0);
    chk("abort_done_q", 32'(bus.done_q), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("abort_no_done", 32'(bus.done), 0);
    run_job(1'b1, LOAD, 4'd3, 4'd0, 4'd3, 5'd1, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
